// File: rtl/prod_byte_unloader_if.sv
// Product-in / byte-out handshake bundle for the product byte unloader.
interface prod_byte_unloader_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8
);
    logic [DATA_W-1:0] datain;
    logic              load;
    logic              load_rdy;
    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;

    // Producer/consumer side (multiplier + byte sink)
    modport master (
        output datain, load, dout_ready,
        input  load_rdy, dout, dout_valid, dout_last, busy
    );

    // Unloader side
    modport slave (
        input  datain, load, dout_ready,
        output load_rdy, dout, dout_valid, dout_last, busy
    );
endinterface

// File: rtl/prod_byte_unloader.sv
// Unloads multiplier products as a byte stream, with a one-word holding
// buffer so the next product can be deposited while the current one drains.
module prod_byte_unloader #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BYTE_W    = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 sclr_n,
    input  logic                 clk_ena,
    prod_byte_unloader_if.slave  bus
);
    localparam int unsigned NBYTES = DATA_W / BYTE_W;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;

    logic              load_xfer;
    logic              beat_done;
    logic              reload;
    logic [DATA_W-1:0] reload_word;

    // Byte presented first from a word, depending on beat order
    function automatic logic [BYTE_W-1:0] head(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) return w[DATA_W-1 -: BYTE_W];
        else           return w[BYTE_W-1:0];
    endfunction

    // Word with its head byte removed
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) return w << BYTE_W;
        else           return w >> BYTE_W;
    endfunction

    // Handshake qualifiers; clk_ena gates both interfaces
    always_comb begin
        load_xfer = bus.load & ~hold_full_q & clk_ena;
        beat_done = dout_valid_q & bus.dout_ready & clk_ena;
    end

    // Next-state: shift-register reload, beat advance and hold buffer fill
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        reload       = 1'b0;
        reload_word  = bus.datain;

        if (clk_ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (load_xfer) begin
                        reload      = 1'b1;
                        reload_word = bus.datain;
                    end
                end
                ST_SEND: begin
                    if (beat_done) begin
                        if (dout_last_q) begin
                            if (hold_full_q) begin
                                reload      = 1'b1;
                                reload_word = hold_q;
                                hold_full_d = 1'b0;
                            end else if (load_xfer) begin
                                reload      = 1'b1;
                                reload_word = bus.datain;
                            end else begin
                                dout_valid_d = 1'b0;
                                dout_last_d  = 1'b0;
                                cnt_d        = '0;
                                state_d      = ST_IDLE;
                            end
                        end else begin
                            dout_d      = head(shift_q);
                            shift_d     = advance(shift_q);
                            cnt_d       = CNT_W'(cnt_q + 1'b1);
                            dout_last_d = (CNT_W'(cnt_q + 1'b1) == LAST_CNT);
                        end
                    end
                    // A load not consumed by a direct reload parks in the hold buffer
                    if (load_xfer && !reload) begin
                        hold_d      = bus.datain;
                        hold_full_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (reload) begin
                dout_d       = head(reload_word);
                shift_d      = advance(reload_word);
                cnt_d        = '0;
                dout_valid_d = 1'b1;
                dout_last_d  = (NBYTES == 1);
                state_d      = ST_SEND;
            end
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign bus.load_rdy   = ~hold_full_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.busy       = dout_valid_q | hold_full_q;

endmodule

// File: tb/tb_prod_byte_unloader.sv
// Directed bench for prod_byte_unloader: LSB-first and MSB-first instances,
// byte stream checked against a scoreboard of expected {last, byte} beats.
module tb_prod_byte_unloader;
    logic clk;
    logic sclr_n;
    logic clk_ena;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] q_l[$];
    logic [8:0] q_m[$];

    prod_byte_unloader_if #(.DATA_W(16), .BYTE_W(8)) bus_l ();
    prod_byte_unloader_if #(.DATA_W(16), .BYTE_W(8)) bus_m ();

    prod_byte_unloader #(.DATA_W(16), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk     (clk),
        .sclr_n  (sclr_n),
        .clk_ena (clk_ena),
        .bus     (bus_l)
    );

    prod_byte_unloader #(.DATA_W(16), .BYTE_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk     (clk),
        .sclr_n  (sclr_n),
        .clk_ena (clk_ena),
        .bus     (bus_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare any beat completing at the coming edge against the scoreboard
    task automatic check_beats();
        logic [8:0] e;
        if (bus_l.dout_valid === 1'b1 && bus_l.dout_ready && clk_ena) begin
            if (q_l.size() == 0) begin
                chk("lsb_unexpected_beat", 32'(bus_l.dout), 32'h1ff);
            end else begin
                e = q_l.pop_front();
                chk("lsb_dout", 32'(bus_l.dout), 32'(e[7:0]));
                chk("lsb_last", 32'(bus_l.dout_last), 32'(e[8]));
            end
        end
        if (bus_m.dout_valid === 1'b1 && bus_m.dout_ready && clk_ena) begin
            if (q_m.size() == 0) begin
                chk("msb_unexpected_beat", 32'(bus_m.dout), 32'h1ff);
            end else begin
                e = q_m.pop_front();
                chk("msb_dout", 32'(bus_m.dout), 32'(e[7:0]));
                chk("msb_last", 32'(bus_m.dout_last), 32'(e[8]));
            end
        end
    endtask

    // One clock: score the beat, take the edge, settle
    task automatic step();
        check_beats();
        @(posedge clk);
        #1;
    endtask

    task automatic push_l(input logic [15:0] w);
        q_l.push_back({1'b0, w[7:0]});
        q_l.push_back({1'b1, w[15:8]});
    endtask

    task automatic push_m(input logic [15:0] w);
        q_m.push_back({1'b0, w[15:8]});
        q_m.push_back({1'b1, w[7:0]});
    endtask

    initial begin
        sclr_n           = 1'b0;
        clk_ena          = 1'b1;
        bus_l.load       = 1'b0;
        bus_l.datain     = '0;
        bus_l.dout_ready = 1'b1;
        bus_m.load       = 1'b0;
        bus_m.datain     = '0;
        bus_m.dout_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid", 32'(bus_l.dout_valid), 32'h0);
        chk("rst_last", 32'(bus_l.dout_last), 32'h0);
        chk("rst_dout", 32'(bus_l.dout), 32'h0);
        chk("rst_busy", 32'(bus_l.busy), 32'h0);
        chk("rst_load_rdy", 32'(bus_l.load_rdy), 32'h1);
        sclr_n = 1'b1;
        step();

        // 1: single word LSB first, one-cycle latency
        bus_l.load = 1'b1; bus_l.datain = 16'h4567; push_l(16'h4567);
        step();
        bus_l.load = 1'b0;
        chk("t1_latency_valid", 32'(bus_l.dout_valid), 32'h1);
        chk("t1_first_last", 32'(bus_l.dout_last), 32'h0);
        step();
        chk("t1_second_last", 32'(bus_l.dout_last), 32'h1);
        step();
        chk("t1_end_valid", 32'(bus_l.dout_valid), 32'h0);
        chk("t1_end_busy", 32'(bus_l.busy), 32'h0);

        // 2: MSB-first ordering
        bus_m.load = 1'b1; bus_m.datain = 16'h1F2E; push_m(16'h1F2E);
        step();
        bus_m.load = 1'b0;
        chk("t2_first", 32'(bus_m.dout), 32'h1f);
        chk("t2_first_last", 32'(bus_m.dout_last), 32'h0);
        step();
        chk("t2_second_last", 32'(bus_m.dout_last), 32'h1);
        step();
        chk("t2_end_valid", 32'(bus_m.dout_valid), 32'h0);

        // 3: backpressure holds the beat stable
        bus_l.dout_ready = 1'b0;
        bus_l.load = 1'b1; bus_l.datain = 16'hABCD; push_l(16'hABCD);
        step();
        bus_l.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_dout", 32'(bus_l.dout), 32'hcd);
            chk("t3_hold_valid", 32'(bus_l.dout_valid), 32'h1);
        end
        bus_l.dout_ready = 1'b1;
        step();
        chk("t3_release", 32'(bus_l.dout), 32'hab);
        step();
        chk("t3_end_valid", 32'(bus_l.dout_valid), 32'h0);

        // 4: back-to-back through the hold buffer, third load dropped
        bus_l.load = 1'b1; bus_l.datain = 16'h1234; push_l(16'h1234);
        step();
        chk("t4_rdy_before_second", 32'(bus_l.load_rdy), 32'h1);
        bus_l.datain = 16'h5678; push_l(16'h5678);
        step();
        chk("t4_rdy_hold_full", 32'(bus_l.load_rdy), 32'h0);
        chk("t4_busy", 32'(bus_l.busy), 32'h1);
        bus_l.datain = 16'hDEAD;
        step();
        bus_l.load = 1'b0;
        chk("t4_no_bubble_valid", 32'(bus_l.dout_valid), 32'h1);
        chk("t4_rdy_after_reload", 32'(bus_l.load_rdy), 32'h1);
        step();
        chk("t4_last_word_valid", 32'(bus_l.dout_valid), 32'h1);
        step();
        chk("t4_end_valid", 32'(bus_l.dout_valid), 32'h0);

        // 5: clk_ena freeze mid-word
        bus_l.load = 1'b1; bus_l.datain = 16'h9ABC; push_l(16'h9ABC);
        step();
        bus_l.load = 1'b0;
        clk_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_frozen_dout", 32'(bus_l.dout), 32'hbc);
            chk("t5_frozen_valid", 32'(bus_l.dout_valid), 32'h1);
            chk("t5_frozen_last", 32'(bus_l.dout_last), 32'h0);
        end
        clk_ena = 1'b1;
        step();
        chk("t5_resume", 32'(bus_l.dout), 32'h9a);
        step();
        chk("t5_end_valid", 32'(bus_l.dout_valid), 32'h0);

        // 6: reset mid-word with hold full discards everything
        bus_l.dout_ready = 1'b0;
        bus_l.load = 1'b1; bus_l.datain = 16'h2468;
        step();
        bus_l.datain = 16'h1357;
        step();
        bus_l.load = 1'b0;
        chk("t6_pre_rdy", 32'(bus_l.load_rdy), 32'h0);
        sclr_n = 1'b0;
        step();
        sclr_n = 1'b1;
        chk("t6_rst_valid", 32'(bus_l.dout_valid), 32'h0);
        chk("t6_rst_rdy", 32'(bus_l.load_rdy), 32'h1);
        chk("t6_rst_busy", 32'(bus_l.busy), 32'h0);
        bus_l.dout_ready = 1'b1;
        bus_l.load = 1'b1; bus_l.datain = 16'h0F1E; push_l(16'h0F1E);
        step();
        bus_l.load = 1'b0;
        chk("t6_restart_byte0", 32'(bus_l.dout), 32'h1e);
        step();
        step();
        chk("t6_end_valid", 32'(bus_l.dout_valid), 32'h0);
        step();

        chk("lsb_queue_drained", 32'(q_l.size()), 32'h0);
        chk("msb_queue_drained", 32'(q_m.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
